// File: rtl/sr_latch_arbiter.sv
// Round-robin arbiter that drives a bank of gated SR latches through setup/strobe/hold and mirrors their contents.
// Latency: request sampled in IDLE -> gnt next cycle, ack PULSE_CYC+2 cycles after the sampling cycle.
// Backpressure: requesters hold req until ack; one transaction in flight, others wait (no queueing, no abort).
module sr_latch_arbiter #(
    parameter int NREQ      = 4,
    parameter int ADDR_W    = 3,
    parameter int PULSE_CYC = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0]             req_set,
    input  logic [NREQ*ADDR_W-1:0]      req_addr,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             ack,
    output logic                        busy,
    output logic [(1<<ADDR_W)-1:0]      lat_s,
    output logic [(1<<ADDR_W)-1:0]      lat_r,
    output logic [(1<<ADDR_W)-1:0]      lat_c,
    output logic [(1<<ADDR_W)-1:0]      shadow_q
);
    localparam int NLAT  = 1 << ADDR_W;
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PULSE_CYC - 1);

    typedef enum logic [2:0] {
        ST_INIT_SETUP, ST_INIT_STROBE, ST_INIT_HOLD,
        ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   own_q, own_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               op_q, op_d;
    logic               mask_vld_q, mask_vld_d;
    logic [IDX_W-1:0]   mask_idx_q, mask_idx_d;
    logic [NREQ-1:0]    gnt_q, gnt_d, ack_q, ack_d;
    logic               busy_q, busy_d;
    logic [NLAT-1:0]    s_q, s_d, r_q, r_d, c_q, c_d, shadow_d, sel;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    int                 cand;

    // Round-robin pick: scan backwards so the candidate nearest the pointer is written last and wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = (int'(rr_q) + k) % NREQ;
            if (req[cand] && !(mask_vld_q && int'(mask_idx_q) == cand)) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end

    // Sequencer next state; only the winner's op/addr are captured so other requesters' fields never matter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        own_d   = own_q;
        addr_d  = addr_q;
        op_d    = op_q;
        unique case (state_q)
            ST_INIT_SETUP: begin
                state_d = ST_INIT_STROBE;
                cnt_d   = '0;
            end
            ST_INIT_STROBE: begin
                if (cnt_q == CNT_MAX) state_d = ST_INIT_HOLD;
                else                  cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_INIT_HOLD: state_d = ST_IDLE;
            ST_IDLE: begin
                if (win_vld) begin
                    state_d = ST_SETUP;
                    own_d   = win_idx;
                    addr_d  = req_addr[win_idx*ADDR_W +: ADDR_W];
                    op_d    = req_set[win_idx];
                    rr_d    = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = '0;
            end
            ST_STROBE: begin
                if (cnt_q == CNT_MAX) state_d = ST_HOLD;
                else                  cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_INIT_SETUP;
        endcase
    end

    // Output decode from the state being entered, so every pin is a flop with no decode glitches.
    always_comb begin
        sel        = NLAT'(1) << addr_d;
        gnt_d      = '0;
        ack_d      = '0;
        busy_d     = 1'b1;
        s_d        = '0;
        r_d        = '0;
        c_d        = '0;
        shadow_d   = shadow_q;
        mask_vld_d = (state_q == ST_HOLD);
        mask_idx_d = own_q;
        unique case (state_d)
            ST_INIT_SETUP:  r_d = '1;
            ST_INIT_STROBE: begin
                r_d = '1;
                c_d = '1;
            end
            ST_INIT_HOLD: begin
                r_d      = '1;
                shadow_d = '0;
            end
            ST_IDLE: busy_d = 1'b0;
            default: begin
                gnt_d = NREQ'(1) << own_d;
                if (op_d) s_d = sel;
                else      r_d = sel;
                if (state_d == ST_STROBE) c_d = sel;
                if (state_d == ST_HOLD) begin
                    ack_d    = NREQ'(1) << own_d;
                    shadow_d = op_d ? (shadow_q | sel) : (shadow_q & ~sel);
                end
            end
        endcase
    end

    // State and output registers; reset drops every pin at once and restarts the bank clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT_SETUP;
            cnt_q      <= '0;
            rr_q       <= '0;
            own_q      <= '0;
            addr_q     <= '0;
            op_q       <= 1'b0;
            mask_vld_q <= 1'b0;
            mask_idx_q <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b1;
            s_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            shadow_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            own_q      <= own_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            mask_vld_q <= mask_vld_d;
            mask_idx_q <= mask_idx_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            s_q        <= s_d;
            r_q        <= r_d;
            c_q        <= c_d;
            shadow_q   <= shadow_d;
        end
    end

    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign busy  = busy_q;
    assign lat_s = s_q;
    assign lat_r = r_q;
    assign lat_c = c_q;
endmodule

// File: tb/tb_sr_latch_arbiter.sv
module tb_sr_latch_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 3;
    localparam int P    = 2;
    localparam int NLAT = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   req_set = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ-1:0]   gnt, ack;
    logic              busy;
    logic [NLAT-1:0]   lat_s, lat_r, lat_c, shadow_q;

    int n_checks = 0;
    int n_errors = 0;

    sr_latch_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .PULSE_CYC(P)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_set(req_set), .req_addr(req_addr),
        .gnt(gnt), .ack(ack), .busy(busy), .lat_s(lat_s), .lat_r(lat_r), .lat_c(lat_c),
        .shadow_q(shadow_q)
    );

    always #5 clk = ~clk;

    // Reference model: cycle offsets within the init sequence or within a transaction.
    int              m_init;   // -1 done, else cycles since reset release (0..P+1)
    int              m_tk;     // -1 none, else 0=setup, 1..P=strobe, P+1=hold
    int              m_own, m_addr, m_rr, m_masked;
    bit              m_op;
    logic [NLAT-1:0] m_shadow;

    task automatic model_reset();
        m_init = 0; m_tk = -1; m_rr = 0; m_masked = -1; m_shadow = '0;
        m_own = 0; m_addr = 0; m_op = 1'b0;
    endtask

    task automatic model_edge();
        int masked_now;
        bit found;
        masked_now = m_masked;
        m_masked   = -1;
        found      = 1'b0;
        if (m_init >= 0) begin
            if (m_init == P + 1) m_init = -1;
            else begin
                m_init++;
                if (m_init == P + 1) m_shadow = '0;
            end
        end else if (m_tk >= 0) begin
            if (m_tk == P + 1) begin
                m_tk = -1;
                m_masked = m_own;
            end else begin
                m_tk++;
                if (m_tk == P + 1) m_shadow[m_addr] = m_op;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_rr + k) % NREQ;
                if (!found && req[i] && i != masked_now) begin
                    found  = 1'b1;
                    m_tk   = 0;
                    m_own  = i;
                    m_addr = int'(req_addr[i*AW +: AW]);
                    m_op   = req_set[i];
                    m_rr   = (i + 1) % NREQ;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [NREQ-1:0] e_gnt, e_ack;
        logic [NLAT-1:0] e_s, e_r, e_c;
        logic            e_busy;
        e_gnt = '0; e_ack = '0; e_s = '0; e_r = '0; e_c = '0;
        e_busy = (m_init >= 0) || (m_tk >= 0);
        if (m_init >= 1) e_r = '1;
        if (m_init >= 1 && m_init <= P) e_c = '1;
        if (m_tk >= 0) begin
            e_gnt[m_own] = 1'b1;
            if (m_op) e_s[m_addr] = 1'b1;
            else      e_r[m_addr] = 1'b1;
            if (m_tk >= 1 && m_tk <= P) e_c[m_addr] = 1'b1;
            if (m_tk == P + 1) e_ack[m_own] = 1'b1;
        end
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("ack", 32'(ack), 32'(e_ack));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("lat_s", 32'(lat_s), 32'(e_s));
        chk("lat_r", 32'(lat_r), 32'(e_r));
        chk("lat_c", 32'(lat_c), 32'(e_c));
        chk("shadow", 32'(shadow_q), 32'(m_shadow));
        chk("s_and_r", 32'(lat_s & lat_r), 32'd0);
        chk("c_without_pin", 32'(lat_c & ~(lat_s | lat_r)), 32'd0);
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        @(negedge clk);
        compare_all();
    endtask

    typedef struct {
        int              id;
        bit              set;
        int              addr;
        logic [NLAT-1:0] exp_pin;
        logic [NLAT-1:0] exp_shadow;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int nb, nc, n;
        bit got;
        int order[$];
        logic [NREQ-1:0] pg;

        vecs[0] = '{0, 1'b1, 5, 8'h20, 8'h20};
        vecs[1] = '{2, 1'b0, 5, 8'h20, 8'h00};
        vecs[2] = '{1, 1'b1, 0, 8'h01, 8'h01};
        vecs[3] = '{3, 1'b1, 7, 8'h80, 8'h81};
        vecs[4] = '{3, 1'b1, 7, 8'h80, 8'h81};
        vecs[5] = '{0, 1'b0, 0, 8'h01, 8'h80};
        vecs[6] = '{2, 1'b1, 3, 8'h08, 8'h88};

        // Reset state and init sequence
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        nb = 0; nc = 0;
        while (busy && nb < 20) begin
            nb++;
            if (lat_c == 8'hFF) nc++;
            step();
        end
        chk("init_busy_cycles", 32'(nb), 32'd4);
        chk("init_strobe_cycles", 32'(nc), 32'd2);

        // Single transactions from the table
        foreach (vecs[v]) begin
            req      = '0;
            req_set  = 4'($urandom);
            req_addr = 12'($urandom);
            req[vecs[v].id] = 1'b1;
            req_set[vecs[v].id] = vecs[v].set;
            req_addr[vecs[v].id*AW +: AW] = 3'(vecs[v].addr);
            n = 0; got = 1'b0;
            while (!got && n < 20) begin
                step();
                n++;
                if (n == 1) begin
                    chk("setup_s", 32'(lat_s), vecs[v].set ? 32'(vecs[v].exp_pin) : 32'd0);
                    chk("setup_r", 32'(lat_r), vecs[v].set ? 32'd0 : 32'(vecs[v].exp_pin));
                    chk("setup_c", 32'(lat_c), 32'd0);
                end
                if (n == 2) chk("strobe_c", 32'(lat_c), 32'(vecs[v].exp_pin));
                got = ack[vecs[v].id];
            end
            chk("ack_latency", 32'(n), 32'(P + 2));
            chk("table_shadow", 32'(shadow_q), 32'(vecs[v].exp_shadow));
            req = '0;
            repeat (2) step();
        end

        // Requester holds req through the IDLE cycle after ack: no regrant; later re-raise is granted
        req = 4'b0010; req_set = 4'b0010; req_addr = 12'(2 << AW);
        n = 0;
        while (!ack[1] && n < 20) begin step(); n++; end
        chk("hold_req_ack_seen", 32'(ack[1]), 32'd1);
        step();
        step();
        chk("no_regrant", 32'(gnt), 32'd0);
        req = '0;
        repeat (3) begin step(); chk("no_regrant_idle", 32'(gnt), 32'd0); end
        req = 4'b0010;
        step();
        chk("regrant", 32'(gnt), 32'b0010);
        n = 0;
        while (!ack[1] && n < 20) begin step(); n++; end
        req = '0;
        repeat (2) step();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            req      = 4'($urandom);
            req_set  = 4'($urandom);
            req_addr = 12'($urandom);
            step();
        end
        req = '0;
        repeat (8) step();

        // Async reset during STROBE, then continuous requests across the init replay
        req = 4'b0001; req_set = 4'b0001; req_addr = 12'd3;
        n = 0;
        while (gnt == 0 && n < 20) begin step(); n++; end
        step();
        chk("pre_reset_strobe", 32'(lat_c), 32'h08);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_lat_c", 32'(lat_c), 32'd0);
        chk("arst_lat_s", 32'(lat_s), 32'd0);
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_busy", 32'(busy), 32'd1);
        model_reset();
        req = 4'b1111; req_set = 4'b0101; req_addr = 12'($urandom);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        pg = '0;
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            step();
            if (gnt != 0 && pg == 0) begin
                for (int b = 0; b < NREQ; b++) if (gnt[b]) order.push_back(b);
            end
            pg = gnt;
        end
        chk("rr_grant_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < order.size(); i++) chk("rr_order", 32'(order[i]), 32'(i % NREQ));
        req = '0;
        repeat (8) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
